// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, canonical NOP and the fetch queue entry.
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order {inst, pc} queue between Fetch and Decode with first-word-fall-through head
// and single-cycle flush on branch redirect.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = core_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     kill,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_inst,
  output logic [XLEN-1:0]          out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  import core_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             enq;
  logic             deq;

  // Ready and valid come only from the registered count, never from the other side.
  assign in_ready    = (count != CNT_W'(DEPTH));
  assign out_valid   = (count != '0);
  assign almost_full = (count >= CNT_W'(DEPTH - 1));

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  always_comb begin
    out_inst = XLEN'(NOP_INST);
    out_pc   = '0;
    if (out_valid) begin
      out_inst = mem[head].inst;
      out_pc   = mem[head].pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(1);
      end
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (enq && !reset && !kill) begin
      mem[tail].inst <= in_inst;
      mem[tail].pc   <= in_pc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based scoreboard of enqueued entries.
module tb_fetch_buffer;
  import core_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset, kill, in_valid, out_ready;
  logic            in_ready, out_valid, almost_full;
  logic [XLEN-1:0] in_inst, in_pc, out_inst, out_pc;
  logic [CW-1:0]   count;

  int           num_checks = 0;
  int           num_errors = 0;
  fetch_entry_t model_q[$];
  bit           track_seq  = 1'b0;
  bit           seq_started = 1'b0;
  logic [31:0]  last_pc;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0093};
  endfunction

  // Drive one cycle, check the current outputs against the model, then advance one edge.
  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit ordy, input bit kl, input bit rs, output bit acc);
    int          sz;
    bit          enq, deq;
    logic [31:0] exp_inst, exp_pc;
    fetch_entry_t e;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; kill = kl; reset = rs;
    sz = model_q.size();
    exp_inst = NOP_INST;
    exp_pc   = '0;
    if (sz != 0) begin
      exp_inst = model_q[0].inst;
      exp_pc   = model_q[0].pc;
    end
    check_val("count",       64'(count),       64'(sz));
    check_val("in_ready",    64'(in_ready),    64'(sz != DEPTH));
    check_val("out_valid",   64'(out_valid),   64'(sz != 0));
    check_val("almost_full", 64'(almost_full), 64'(sz >= DEPTH - 1));
    check_val("out_inst",    64'(out_inst),    64'(exp_inst));
    check_val("out_pc",      64'(out_pc),      64'(exp_pc));
    enq = v && (sz != DEPTH);
    deq = ordy && (sz != 0);
    acc = 1'b0;
    if (rs || kl) begin
      model_q.delete();
    end else begin
      if (deq) begin
        if (track_seq && seq_started)
          check_val("seq_pc", 64'(out_pc), 64'(last_pc + 32'd4));
        last_pc     = out_pc;
        seq_started = 1'b1;
        void'(model_q.pop_front());
      end
      if (enq) begin
        e.inst = inst;
        e.pc   = pc;
        model_q.push_back(e);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          acc;
    logic [31:0] pc;
    logic [31:0] t1_inst [3];
    t1_inst[0] = 32'h00500093;
    t1_inst[1] = 32'h00100113;
    t1_inst[2] = 32'h002081b3;

    reset = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;

    // 1: three enqueues, no consumption
    for (int i = 0; i < 3; i++)
      step(1'b1, t1_inst[i], 32'(i * 4), 1'b0, 1'b0, 1'b0, acc);

    // 2: fill, then full with deq refuses the enq; it lands on the next cycle
    step(1'b1, inst_of(32'h0C), 32'h0C, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, inst_of(32'h10), 32'h10, 1'b1, 1'b0, 1'b0, acc);
    check_val("full_refuse", 64'(acc), 64'(0));
    step(1'b1, inst_of(32'h10), 32'h10, 1'b0, 1'b0, 1'b0, acc);
    check_val("enq_after", 64'(acc), 64'(1));

    // 3: steady stream; refused entries are re-presented
    track_seq = 1'b1;
    pc = 32'h14;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, inst_of(pc), pc, 1'b1, 1'b0, 1'b0, acc);
      if (acc) pc = pc + 32'd4;
    end
    track_seq = 1'b0;

    // 4: kill with traffic on both sides
    check_val("pre_kill_cnt", 64'(count), 64'(3));
    step(1'b1, inst_of(32'hDEAD0), 32'hDEAD0, 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);

    // 5: no same-cycle bypass when empty
    step(1'b1, inst_of(32'h40), 32'h40, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, inst_of(32'h44), 32'h44, 1'b0, 1'b0, 1'b0, acc);

    // 6: reset mid-operation with enq active
    check_val("pre_rst_cnt", 64'(count), 64'(2));
    step(1'b1, inst_of(32'h48), 32'h48, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, inst_of(32'h80), 32'h80, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Instruction queue between Fetch and Decode. It decouples the fetch path from Decode stalls and absorbs fetch bursts.
- Holds up to DEPTH {instruction, pc} pairs in order.
- Presents the oldest entry first-word-fall-through.
- Flushed in one cycle by kill on a branch mispredict.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
XLEN, 32, instruction and pc width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
kill  in  1  flush all entries (branch redirect); synchronous
in_valid  in  1  Fetch presents a valid instruction
in_inst  in  XLEN  fetched instruction
in_pc  in  XLEN  pc of in_inst
in_ready  out  1  buffer can accept an entry this cycle
out_valid  out  1  head entry is valid
out_inst  out  XLEN  head instruction (NOP when empty)
out_pc  out  XLEN  head pc (0 when empty)
out_ready  in  1  Decode consumes head this cycle (driven as !stall_dc)
count  out  $clog2(DEPTH)+1  current occupancy
almost_full  out  1  count >= DEPTH-1

Behaviour:
- Reset (reset=1 at edge): head=0, tail=0, count=0.
  - Outputs then read in_ready=1, out_valid=0, out_inst=NOP (32'h00000013), out_pc=0, almost_full=0.
  - Storage contents are don't-care.
- enq = in_valid && in_ready; deq = out_valid && out_ready.
- in_ready = (count != DEPTH).
  - Depends only on registered count. No combinational path from out_ready.
  - A full buffer with a simultaneous deq still refuses enq that cycle.
- out_valid = (count != 0). out_inst/out_pc are read combinationally from mem[head]; they are NOP/0 when count == 0.
- Latency: an entry enqueued at edge N is visible at the outputs after edge N. There is no same-cycle bypass, even when empty.
- On enq: mem[tail] <= {in_inst, in_pc}; tail <= tail+1 mod DEPTH.
- On deq: head <= head+1 mod DEPTH.
- Count update:
  - +1 for enq only.
  - -1 for deq only.
  - Unchanged for both or neither.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full vs empty is distinguished only by count.
- Simultaneous enq and deq:
  - When empty, only enq is possible, since out_valid=0.
  - When full, only deq is possible.
  - Otherwise both occur and count holds.
- Priority per edge: reset > kill > enq/deq.
  - kill=1: head=tail=count=0 next edge. Any enq/deq in that cycle is discarded.
  - An instruction presented during kill is lost. Fetch must re-present it from the redirected pc.
- kill while empty: no effect other than pointer reset.
- Reset asserted mid-operation: same as kill. Fetch and Decode see the empty buffer on the next cycle.
- Outputs never carry X after the first reset, including when count == 0.
- No state machine beyond the count. Behaviour is fully defined by the triple (head, tail, count).

Decomposition:
- Shared package core_pkg:
  - XLEN
  - NOP_INST = 32'h00000013
  - typedef fetch_entry_t (packed struct {inst, pc})
- Storage is an inline register array of fetch_entry_t. No sub-module is needed.
- cpu_top instantiates fetch_buffer between the Fetch and Decode instances:
  - in_ready gates Fetch stall.
  - out_valid/out_ready replace the direct instruction0 handoff.

Test Plan:
1. Reset, then enq pc=0x00,0x04,0x08 (inst 0x00500093, 0x00100113, 0x002081b3) with out_ready=0 -> count=3, almost_full=1, in_ready=1, out_pc=0x00, out_inst=0x00500093.
2. Continue to enq pc=0x0C -> count=4, in_ready=0. Hold in_valid with pc=0x10 and out_ready=1 for one cycle -> deq of 0x00 only, count=3. pc=0x10 enqueues the following cycle.
3. Steady stream, in_valid=1 and out_ready=1 for 12 cycles, pc step 4 -> out_pc sequence strictly increasing by 4, no drop or duplicate, pointers wrap 3 times, count constant.
4. Buffer holding 3 entries, assert kill with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_inst=0x00000013, out_pc=0. The killed-cycle instruction never appears.
5. Empty buffer, in_valid=1 with pc=0x40 -> out_valid=0 that cycle, out_valid=1 and out_pc=0x40 next cycle.
6. reset asserted while count=2 and enq active -> next cycle count=0, in_ready=1, out_valid=0. Subsequent enq of pc=0x80 appears at head.
